// File: rtl/gpu_tri_raster.sv
// Triangle / rectangle rasteriser: scans the clipped bounding box one pixel per clock
// and writes covered pixels to the SRAM framebuffer while video is blanked.
module gpu_tri_raster #(
  parameter int FB_W    = 640,
  parameter int FB_H    = 400,
  parameter int COORD_W = 10,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 18,
  parameter int CNT_W   = 20
) (
  input  logic               I_CLK,
  input  logic               I_RST,
  input  logic               I_VIDEO_ON,
  input  logic               I_CMD_VALID,
  output logic               O_CMD_READY,
  input  logic               I_CMD_MODE,
  input  logic [COORD_W-1:0] I_AX,
  input  logic [COORD_W-1:0] I_AY,
  input  logic [COORD_W-1:0] I_BX,
  input  logic [COORD_W-1:0] I_BY,
  input  logic [COORD_W-1:0] I_CX,
  input  logic [COORD_W-1:0] I_CY,
  input  logic [DATA_W-1:0]  I_CMD_COLOR,
  input  logic [15:0]        I_GPU_DATA,
  output logic [DATA_W-1:0]  O_GPU_DATA,
  output logic [ADDR_W-1:0]  O_GPU_ADDR,
  output logic               O_GPU_WRITE,
  output logic               O_GPU_READ,
  output logic               O_BUSY,
  output logic               O_DONE,
  output logic [CNT_W-1:0]   O_PIX_COUNT
);

  localparam int EW = 2*COORD_W + 3;
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(FB_W - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(FB_H - 1);

  typedef logic signed [EW-1:0] edge_t;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_DONE} state_t;

  state_t state, state_nx;

  logic               mode_q;
  logic [DATA_W-1:0]  color_q;
  logic [COORD_W-1:0] ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
  logic [COORD_W-1:0] minx_q, maxx_q, miny_q, maxy_q;
  logic [COORD_W-1:0] cur_x, cur_y;
  edge_t              dx0_q, dy0_q, dx1_q, dy1_q, dx2_q, dy2_q;
  logic               scan_end, wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   pix_q;

  logic unused_gpu_data;
  assign unused_gpu_data = ^I_GPU_DATA;

  function automatic edge_t sx(input logic [COORD_W-1:0] v);
    return $signed({{(EW-COORD_W){1'b0}}, v});
  endfunction

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Setup-time geometry from the captured command
  logic [COORD_W-1:0] minx_c, miny_c, maxx_raw, maxy_raw, maxx_c, maxy_c;
  edge_t              dx0_c, dy0_c, dx1_c, dy1_c, dx2_c, dy2_c, area_c;
  logic               bbox_empty, zero_area;

  always_comb begin
    minx_c     = min3(ax_q, bx_q, cx_q);
    miny_c     = min3(ay_q, by_q, cy_q);
    maxx_raw   = max3(ax_q, bx_q, cx_q);
    maxy_raw   = max3(ay_q, by_q, cy_q);
    maxx_c     = (maxx_raw > XMAX) ? XMAX : maxx_raw;
    maxy_c     = (maxy_raw > YMAX) ? YMAX : maxy_raw;
    bbox_empty = (minx_c > maxx_c) || (miny_c > maxy_c);
    dx0_c      = sx(bx_q) - sx(ax_q);
    dy0_c      = sx(by_q) - sx(ay_q);
    dx1_c      = sx(cx_q) - sx(bx_q);
    dy1_c      = sx(cy_q) - sx(by_q);
    dx2_c      = sx(ax_q) - sx(cx_q);
    dy2_c      = sx(ay_q) - sx(cy_q);
    area_c     = dx0_c * (sx(cy_q) - sx(ay_q)) - dy0_c * (sx(cx_q) - sx(ax_q));
    zero_area  = !mode_q && (area_c == '0);
  end

  // Per-pixel coverage at the current scan position
  edge_t             e0, e1, e2;
  logic              covered, advance, last_pix;
  logic [ADDR_W-1:0] pix_addr;

  always_comb begin
    e0       = dx0_q * (sx(cur_y) - sx(ay_q)) - dy0_q * (sx(cur_x) - sx(ax_q));
    e1       = dx1_q * (sx(cur_y) - sx(by_q)) - dy1_q * (sx(cur_x) - sx(bx_q));
    e2       = dx2_q * (sx(cur_y) - sx(cy_q)) - dy2_q * (sx(cur_x) - sx(cx_q));
    covered  = mode_q
            || (!e0[EW-1] && !e1[EW-1] && !e2[EW-1])
            || ((e0[EW-1] || e0 == '0) && (e1[EW-1] || e1 == '0) && (e2[EW-1] || e2 == '0));
    advance  = (state == S_SCAN) && !scan_end && !I_VIDEO_ON;
    last_pix = (cur_x == maxx_q) && (cur_y == maxy_q);
    pix_addr = ADDR_W'(cur_y) * ADDR_W'(FB_W) + ADDR_W'(cur_x);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) state <= S_IDLE;
    else       state <= state_nx;
  end

  // SCAN lingers after the last pixel until its pending write has been delivered
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (I_CMD_VALID) state_nx = S_SETUP;
      S_SETUP: state_nx = (bbox_empty || zero_area) ? S_DONE : S_SCAN;
      S_SCAN:  if (scan_end && (!wr_q || !I_VIDEO_ON)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    O_CMD_READY = (state == S_IDLE);
    O_BUSY      = (state != S_IDLE);
    O_DONE      = (state == S_DONE);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      mode_q   <= 1'b0;
      color_q  <= '0;
      ax_q     <= '0; ay_q <= '0; bx_q <= '0; by_q <= '0; cx_q <= '0; cy_q <= '0;
      minx_q   <= '0; maxx_q <= '0; miny_q <= '0; maxy_q <= '0;
      dx0_q    <= '0; dy0_q <= '0; dx1_q <= '0; dy1_q <= '0; dx2_q <= '0; dy2_q <= '0;
      cur_x    <= '0; cur_y <= '0;
      scan_end <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      pix_q    <= '0;
    end else begin
      if (state == S_IDLE && I_CMD_VALID) begin
        mode_q  <= I_CMD_MODE;
        color_q <= I_CMD_COLOR;
        ax_q <= I_AX; ay_q <= I_AY; bx_q <= I_BX; by_q <= I_BY; cx_q <= I_CX; cy_q <= I_CY;
      end
      if (wr_q && !I_VIDEO_ON && pix_q != '1) pix_q <= pix_q + CNT_W'(1);
      if (state == S_SETUP) begin
        minx_q <= minx_c; maxx_q <= maxx_c; miny_q <= miny_c; maxy_q <= maxy_c;
        dx0_q <= dx0_c; dy0_q <= dy0_c; dx1_q <= dx1_c;
        dy1_q <= dy1_c; dx2_q <= dx2_c; dy2_q <= dy2_c;
        cur_x    <= minx_c;
        cur_y    <= miny_c;
        scan_end <= 1'b0;
        pix_q    <= '0;
      end
      if (advance) begin
        wr_q <= covered;
        if (covered) begin
          addr_q <= pix_addr;
          data_q <= color_q;
        end
        if (cur_x == maxx_q) begin
          cur_x <= minx_q;
          if (last_pix) scan_end <= 1'b1;
          else          cur_y    <= cur_y + COORD_W'(1);
        end else begin
          cur_x <= cur_x + COORD_W'(1);
        end
      end else if (!I_VIDEO_ON) begin
        wr_q <= 1'b0;
      end
    end
  end

  assign O_GPU_WRITE = wr_q & ~I_VIDEO_ON;
  assign O_GPU_ADDR  = addr_q;
  assign O_GPU_DATA  = data_q;
  assign O_GPU_READ  = 1'b0;
  assign O_PIX_COUNT = pix_q;

endmodule

// File: tb/tb_gpu_tri_raster.sv
// Scoreboard bench for gpu_tri_raster: a brute-force coverage model queues the
// expected writes, and a negedge monitor pops and compares every actual write.
module tb_gpu_tri_raster;

  logic        clk = 1'b0;
  logic        rst, video_on, cmd_valid, cmd_ready, cmd_mode;
  logic [9:0]  ax, ay, bx, by, cx, cy;
  logic [15:0] cmd_color, gpu_rdata, gpu_wdata;
  logic [17:0] gpu_addr;
  logic        gpu_write, gpu_read, busy, done;
  logic [19:0] pix_count;

  int checks = 0;
  int passed = 0;
  int wr_count = 0;
  int max_addr = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  gpu_tri_raster #(.FB_W(640), .FB_H(400), .COORD_W(10), .DATA_W(16), .ADDR_W(18), .CNT_W(20)) dut (
    .I_CLK(clk), .I_RST(rst), .I_VIDEO_ON(video_on),
    .I_CMD_VALID(cmd_valid), .O_CMD_READY(cmd_ready), .I_CMD_MODE(cmd_mode),
    .I_AX(ax), .I_AY(ay), .I_BX(bx), .I_BY(by), .I_CX(cx), .I_CY(cy),
    .I_CMD_COLOR(cmd_color), .I_GPU_DATA(gpu_rdata), .O_GPU_DATA(gpu_wdata),
    .O_GPU_ADDR(gpu_addr), .O_GPU_WRITE(gpu_write), .O_GPU_READ(gpu_read),
    .O_BUSY(busy), .O_DONE(done), .O_PIX_COUNT(pix_count)
  );

  always @(negedge clk) begin
    if (gpu_write) begin
      logic [33:0] e;
      checks++;
      wr_count++;
      if (int'(gpu_addr) > max_addr) max_addr = int'(gpu_addr);
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected: addr=%0d data=%h, required no write", gpu_addr, gpu_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({gpu_addr, gpu_wdata, video_on} !== {e, 1'b0})
          $display("FAIL write_match: addr=%0d data=%h video_on=%b, required addr=%0d data=%h video_on=0",
                   gpu_addr, gpu_wdata, video_on, e[33:16], e[15:0]);
        else passed++;
      end
    end
  end

  task automatic model_push(input logic mode, input int pax, pay, pbx, pby, pcx, pcy,
                            input logic [15:0] col, output int n);
    int x0, x1, y0, y1, e0, e1, e2, area;
    n = 0;
    x0 = (pax < pbx) ? pax : pbx; x0 = (pcx < x0) ? pcx : x0;
    y0 = (pay < pby) ? pay : pby; y0 = (pcy < y0) ? pcy : y0;
    x1 = (pax > pbx) ? pax : pbx; x1 = (pcx > x1) ? pcx : x1; if (x1 > 639) x1 = 639;
    y1 = (pay > pby) ? pay : pby; y1 = (pcy > y1) ? pcy : y1; if (y1 > 399) y1 = 399;
    area = (pbx - pax) * (pcy - pay) - (pby - pay) * (pcx - pax);
    if (!mode && area == 0) return;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        e0 = (pbx - pax) * (y - pay) - (pby - pay) * (x - pax);
        e1 = (pcx - pbx) * (y - pby) - (pcy - pby) * (x - pbx);
        e2 = (pax - pcx) * (y - pcy) - (pay - pcy) * (x - pcx);
        if (mode || (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
          exp_q.push_back({18'(y * 640 + x), col});
          n++;
        end
      end
  endtask

  // Drives one command and returns at the first negedge after the accept edge
  task automatic start_cmd(input logic mode, input int pax, pay, pbx, pby, pcx, pcy,
                           input logic [15:0] col, output int n);
    model_push(mode, pax, pay, pbx, pby, pcx, pcy, col, n);
    @(negedge clk);
    cmd_mode = mode; cmd_color = col;
    ax = 10'(pax); ay = 10'(pay); bx = 10'(pbx); by = 10'(pby); cx = 10'(pcx); cy = 10'(pcy);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_mode = ~mode; cmd_color = 16'hDEAD;
    ax = 10'($urandom); ay = 10'($urandom); bx = 10'($urandom);
    by = 10'($urandom); cx = 10'($urandom); cy = 10'($urandom);
  endtask

  task automatic wait_done(input int limit, output int first_n, output int done_n, output int done_cnt);
    first_n = -1; done_n = -1; done_cnt = 0;
    for (int n = 1; n <= limit; n++) begin
      if (gpu_write && first_n < 0) first_n = n;
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (done_n > 0 && n >= done_n + 3) break;
      @(negedge clk);
    end
    if (done_n < 0) begin
      checks++;
      $display("FAIL done_timeout: no DONE within %0d cycles, required DONE", limit);
    end
  endtask

  task automatic check_cmd(input string name, input int exp_n, input int w0, input int done_cnt);
    checks++;
    if ((wr_count - w0) !== exp_n || exp_q.size() !== 0)
      $display("FAIL %s_writes: got %0d writes (%0d left queued), required %0d", name, wr_count - w0, exp_q.size(), exp_n);
    else passed++;
    checks++;
    if (pix_count !== 20'(exp_n)) $display("FAIL %s_pix_count: got %0d, required %0d", name, pix_count, exp_n);
    else passed++;
    checks++;
    if (done_cnt !== 1) $display("FAIL %s_done_pulses: got %0d, required 1", name, done_cnt);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; video_on = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_color = '0;
    ax = '0; ay = '0; bx = '0; by = '0; cx = '0; cy = '0; gpu_rdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, gpu_write, gpu_read, pix_count, gpu_addr, gpu_wdata} !== {1'b1, 58'd0})
      $display("FAIL reset_outputs: ready=%b busy=%b done=%b write=%b read=%b pix=%0d addr=%0d data=%h, required ready=1 rest 0",
               cmd_ready, busy, done, gpu_write, gpu_read, pix_count, gpu_addr, gpu_wdata);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_rect;
    int n, w0, f, d, dc;
    w0 = wr_count;
    start_cmd(1'b1, 2, 3, 5, 4, 2, 3, 16'hF00D, n);
    checks++;
    if (n !== 8 || exp_q[0][33:16] !== 18'd1922 || exp_q[3][33:16] !== 18'd1925 ||
        exp_q[4][33:16] !== 18'd2562 || exp_q[7][33:16] !== 18'd2565)
      $display("FAIL rect_model: model gave %0d pixels, required 8 at 1922..1925, 2562..2565", n);
    else passed++;
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0)
      $display("FAIL rect_busy: busy=%b ready=%b, required busy=1 ready=0", busy, cmd_ready);
    else passed++;
    wait_done(200, f, d, dc);
    checks++;
    if (f !== 3) $display("FAIL rect_first_write_latency: got %0d, required 3", f);
    else passed++;
    check_cmd("rect", 8, w0, dc);
  endtask

  task automatic test_triangle;
    int n, w0, f, d, dc;
    w0 = wr_count;
    start_cmd(1'b0, 0, 0, 4, 0, 0, 4, 16'h1234, n);
    wait_done(200, f, d, dc);
    check_cmd("tri_ccw", 15, w0, dc);
    w0 = wr_count;
    start_cmd(1'b0, 0, 0, 0, 4, 4, 0, 16'h4321, n);
    wait_done(200, f, d, dc);
    check_cmd("tri_cw", 15, w0, dc);
  endtask

  task automatic test_collinear;
    int n, w0, f, d, dc;
    w0 = wr_count;
    start_cmd(1'b0, 0, 0, 5, 5, 9, 9, 16'hAAAA, n);
    wait_done(100, f, d, dc);
    checks++;
    if (d !== 2) $display("FAIL collinear_done_latency: got %0d, required 2", d);
    else passed++;
    check_cmd("collinear", 0, w0, dc);
  endtask

  task automatic test_clip;
    int n, w0, f, d, dc;
    w0 = wr_count;
    max_addr = 0;
    start_cmd(1'b0, 630, 390, 700, 390, 630, 500, 16'h5555, n);
    wait_done(1000, f, d, dc);
    checks++;
    if (max_addr > 255999 || wr_count == w0)
      $display("FAIL clip_max_addr: got %0d with %0d writes, required <=255999 and >0 writes", max_addr, wr_count - w0);
    else passed++;
    check_cmd("clip", n, w0, dc);
  endtask

  task automatic test_stall;
    int n, w0, f, d, dc;
    bit stop;
    w0 = wr_count;
    stop = 1'b0;
    fork
      begin
        start_cmd(1'b0, 0, 0, 4, 0, 0, 4, 16'h7777, n);
        wait_done(2000, f, d, dc);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          repeat (7) @(negedge clk);
          if (!stop) video_on = ~video_on;
        end
      end
    join
    video_on = 1'b0;
    check_cmd("stall", 15, w0, dc);
  endtask

  task automatic test_reset_midscan;
    int n, w0, f, d, dc;
    start_cmd(1'b1, 0, 0, 30, 30, 0, 0, 16'hBEEF, n);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    checks++;
    if ({gpu_write, cmd_ready, busy, done} !== 4'b0100)
      $display("FAIL midscan_reset: write=%b ready=%b busy=%b done=%b, required write=0 ready=1 busy=0 done=0",
               gpu_write, cmd_ready, busy, done);
    else passed++;
    rst = 1'b0;
    w0 = wr_count;
    start_cmd(1'b1, 10, 20, 12, 21, 11, 20, 16'hC0DE, n);
    wait_done(200, f, d, dc);
    check_cmd("after_reset", 6, w0, dc);
  endtask

  initial begin
    test_reset;
    test_rect;
    test_triangle;
    test_collinear;
    test_clip;
    test_stall;
    test_reset_midscan;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
